// File: rtl/ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ctrl_pkg                                                  |
// | Purpose  : Shared types and constants for the multi-cycle control    |
// |            sequencer and its opcode decoder.                         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package ctrl_pkg;

    // Sequencer states; IDLE and HALT are the only non-busy states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Opcode classes on the low three opcode bits. ALU-immediate covers
    // 100/101 and ALU-register covers 110/111.
    localparam logic [2:0] OP_LOAD   = 3'b000;
    localparam logic [2:0] OP_STORE  = 3'b001;
    localparam logic [2:0] OP_BRANCH = 3'b010;
    localparam logic [2:0] OP_HALT   = 3'b011;
    localparam logic [2:0] OP_ALUI   = 3'b100;
    localparam logic [2:0] OP_ALUR   = 3'b110;

    // ALU pass-through (a+0); consumers take the low OPWIDTH bits.
    localparam logic [31:0] ALUOP_PASS = '1;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ctrl_decode                                               |
// | Purpose  : Combinational opcode-class decode of the latched opcode   |
// |            into class flags and the static datapath selects.         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ctrl_decode #(
    parameter int OPWIDTH = 3
) (
    input  logic [2:0]         op,
    output logic               is_load,
    output logic               is_store,
    output logic               is_branch,
    output logic               alusrc,
    output logic               memtoreg,
    output logic [OPWIDTH-1:0] aluop
);
    import ctrl_pkg::*;

    logic w_is_alu;

    // Class flags and static selects derived purely from the opcode.
    always_comb begin
        w_is_alu  = op[2];
        is_load   = (op == OP_LOAD);
        is_store  = (op == OP_STORE);
        is_branch = (op == OP_BRANCH);
        alusrc    = ({op[2:1], 1'b0} == OP_ALUI);
        memtoreg  = (op == OP_LOAD);
        aluop     = ALUOP_PASS[OPWIDTH-1:0];
        if (w_is_alu) begin
            aluop = OPWIDTH'(op);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ctrl_sequencer                                            |
// | Purpose  : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer    |
// |            with a timed data-memory handshake and sticky halt status.|
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ctrl_sequencer #(
    parameter int MCODEBITS   = 3,
    parameter int OPWIDTH     = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MCODEBITS-1:0] instr,
    input  logic                 mem_ready,
    input  logic                 branch_taken,
    output logic                 ir_load,
    output logic                 pc_en,
    output logic                 pc_branch,
    output logic                 RegDst,
    output logic                 Branch,
    output logic                 MemtoReg,
    output logic                 ALUSrc,
    output logic                 MemWrite,
    output logic                 MemRead,
    output logic                 RegWrite,
    output logic [OPWIDTH-1:0]   ALUOp,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    import ctrl_pkg::*;

    localparam int              c_CW       = $clog2(MEM_TIMEOUT + 1);
    // Value of the counter during the final permitted MEM cycle.
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(MEM_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_op;
    logic [c_CW-1:0]   r_cnt;
    logic              r_err;
    logic              w_set_err;
    logic              w_instr_hi;
    logic [2:0]        w_instr_op;
    logic              w_static;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_is_branch;
    logic              w_alusrc;
    logic              w_memtoreg;

    assign w_instr_op = instr[2:0];

    // Any opcode bit above bit 2 marks the instruction illegal.
    if (MCODEBITS > 3) begin : g_instr_hi
        assign w_instr_hi = |instr[MCODEBITS-1:3];
    end else begin : g_instr_nohi
        assign w_instr_hi = 1'b0;
    end

    ctrl_decode #(
        .OPWIDTH (OPWIDTH)
    ) u_decode (
        .op        (r_op),
        .is_load   (w_is_load),
        .is_store  (w_is_store),
        .is_branch (w_is_branch),
        .alusrc    (w_alusrc),
        .memtoreg  (w_memtoreg),
        .aluop     (ALUOp)
    );

    // State, latched opcode, MEM wait counter and sticky error register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_DECODE) begin
                r_op <= w_instr_op;
            end
            // Counter only runs while staying in MEM, so it is zero on entry.
            if ((r_state == ST_MEM) && (w_state_nxt == ST_MEM)) begin
                r_cnt <= r_cnt + c_CW'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Next-state selection and per-state strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_set_err   = 1'b0;
        ir_load     = 1'b0;
        pc_en       = 1'b0;
        pc_branch   = 1'b0;
        Branch      = 1'b0;
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        RegWrite    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_load     = 1'b1;
                w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_instr_hi) begin
                    w_state_nxt = ST_HALT;
                    w_set_err   = 1'b1;
                end else if (w_instr_op == OP_HALT) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_is_branch) begin
                    Branch      = 1'b1;
                    pc_en       = 1'b1;
                    pc_branch   = branch_taken;
                    w_state_nxt = ST_FETCH;
                end else if (w_is_load || w_is_store) begin
                    w_state_nxt = ST_MEM;
                end else begin
                    w_state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                MemRead  = w_is_load;
                MemWrite = w_is_store;
                // A ready arriving in the final allowed cycle still succeeds.
                if (mem_ready) begin
                    if (w_is_store) begin
                        pc_en       = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_WB;
                    end
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = ST_HALT;
                    w_set_err   = 1'b1;
                end
            end
            ST_WB: begin
                RegWrite    = 1'b1;
                pc_en       = 1'b1;
                w_state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Static selects are only presented while an instruction is executing.
    assign w_static = (r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB);
    assign ALUSrc   = w_static && w_alusrc;
    assign MemtoReg = w_static && w_memtoreg;
    assign RegDst   = 1'b0;
    assign busy     = (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign done     = (r_state == ST_HALT);
    assign err      = r_err;

endmodule
`default_nettype wire
